// File: rtl/foc_uart_regbank.sv
`default_nettype none
// ============================================================================
// Module   : foc_uart_regbank
// Purpose  : UART (8N1) framed register bank for the FOC controller.
//            Frame format: A5 ADDR D3 D2 D1 D0 CSUM, where CSUM is the
//            modulo-256 sum of ADDR..D0 and data is big-endian.
//            A matching frame with a mapped address commits the register
//            in one cycle, together with an O_frame_ok pulse. A checksum,
//            address, framing or inter-byte timeout error pulses O_frame_err.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   BAUD_DIV     clock cycles per UART bit (347 -> 115200 baud @ 40 MHz)
//   TIMEOUT_CYC  maximum idle cycles between bytes of one frame
// Ports
//   I_clk_40m        in   1    system clock
//   I_rst            in   1    asynchronous active-high reset
//   I_uart_rx        in   1    UART receive line (asynchronous, idle high)
//   O_uart_tx        out  1    UART transmit line (acknowledge byte)
//   O_en             out  1    motor enable            (reg 0x00)
//   O_control_mode   out  2    loop mode               (reg 0x01)
//   O_motor_polePair out  6    pole pairs              (reg 0x02)
//   O_dir_bits       out  3    direction bits          (reg 0x03)
//   O_targets        out  96   six 16-bit targets      (reg 0x10..0x15)
//   O_gains          out  384  twelve 32-bit gains     (reg 0x20..0x2B)
//   O_frame_ok       out  1    commit pulse
//   O_frame_err      out  1    error pulse
// Build option
//   REGBANK_TX_ACK_EN  when defined, an acknowledge byte is sent on
//                      O_uart_tx after each frame (0x5A ok / 0xEE error);
//                      otherwise O_uart_tx is tied high.
// ============================================================================
module foc_uart_regbank #(
  parameter int BAUD_DIV    = 347,
  parameter int TIMEOUT_CYC = 400000
) (
  input  logic         I_clk_40m,
  input  logic         I_rst,
  input  logic         I_uart_rx,
  output logic         O_uart_tx,
  output logic         O_en,
  output logic [1:0]   O_control_mode,
  output logic [5:0]   O_motor_polePair,
  output logic [2:0]   O_dir_bits,
  output logic [95:0]  O_targets,
  output logic [383:0] O_gains,
  output logic         O_frame_ok,
  output logic         O_frame_err
);

  localparam int BD_W = $clog2(BAUD_DIV);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [BD_W-1:0] c_baud_last = BD_W'(BAUD_DIV - 1);
  localparam logic [BD_W-1:0] c_baud_half = BD_W'(BAUD_DIV / 2);
  localparam logic [TO_W-1:0] c_to_max    = TO_W'(TIMEOUT_CYC);
  localparam logic [7:0]      c_sync_byte = 8'hA5;

  // --------------------------------------------------------------------------
  // Input synchroniser and falling-edge detect
  // --------------------------------------------------------------------------
  logic r_rx_meta, r_rx_sync, r_rx_prev;

  always_ff @(posedge I_clk_40m or posedge I_rst) begin
    if (I_rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= I_uart_rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  logic w_rx_fall;
  assign w_rx_fall = r_rx_prev & ~r_rx_sync;

  // --------------------------------------------------------------------------
  // UART receiver
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t       r_rx_state, w_rx_next;
  logic [BD_W-1:0] r_baud_cnt;
  logic [2:0]      r_bit_idx;
  logic [7:0]      r_rx_shift;
  logic            w_baud_half, w_baud_last;
  logic            w_rx_done, w_rx_ferr;

  assign w_baud_half = (r_baud_cnt == c_baud_half);
  assign w_baud_last = (r_baud_cnt == c_baud_last);

  always_ff @(posedge I_clk_40m or posedge I_rst) begin
    if (I_rst) r_rx_state <= RX_IDLE;
    else       r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next = r_rx_state;
    w_rx_done = 1'b0;
    w_rx_ferr = 1'b0;
    case (r_rx_state)
      RX_IDLE:  if (w_rx_fall) w_rx_next = RX_START;
      // A start bit that is high again at mid-bit was only a glitch.
      RX_START: if (w_baud_half) w_rx_next = r_rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_baud_last && (r_bit_idx == 3'd7)) w_rx_next = RX_STOP;
      RX_STOP: begin
        if (w_baud_last) begin
          w_rx_next = RX_IDLE;
          w_rx_done = r_rx_sync;
          w_rx_ferr = ~r_rx_sync;
        end
      end
      default:  w_rx_next = RX_IDLE;
    endcase
  end

  // Counter restarts at mid start bit, so every later sample is mid-bit.
  always_ff @(posedge I_clk_40m or posedge I_rst) begin
    if (I_rst) begin
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_rx_shift <= '0;
    end else begin
      if ((r_rx_state == RX_IDLE) || ((r_rx_state == RX_START) && w_baud_half) || w_baud_last)
        r_baud_cnt <= '0;
      else
        r_baud_cnt <= r_baud_cnt + 1'b1;

      if (r_rx_state == RX_START) begin
        r_bit_idx <= '0;
      end else if ((r_rx_state == RX_DATA) && w_baud_last) begin
        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
        r_bit_idx  <= r_bit_idx + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame parser
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {P_IDLE, P_ADDR, P_D3, P_D2, P_D1, P_D0, P_CSUM} p_state_t;

  p_state_t        r_p_state, w_p_next;
  logic [7:0]      r_addr;
  logic [31:0]     r_data;
  logic [7:0]      r_sum;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_commit_req, r_cerr_req;
  logic            w_timeout, w_mapped, w_csum_byte, w_csum_good;

  // A byte completing in the same cycle as the timeout wins.
  assign w_timeout   = (r_p_state != P_IDLE) && (r_to_cnt == c_to_max) && !w_rx_done;
  assign w_mapped    = (r_addr <= 8'h03) ||
                       ((r_addr >= 8'h10) && (r_addr <= 8'h15)) ||
                       ((r_addr >= 8'h20) && (r_addr <= 8'h2B));
  assign w_csum_byte = w_rx_done && (r_p_state == P_CSUM);
  assign w_csum_good = (r_rx_shift == r_sum) && w_mapped;

  always_ff @(posedge I_clk_40m or posedge I_rst) begin
    if (I_rst) r_p_state <= P_IDLE;
    else       r_p_state <= w_p_next;
  end

  always_comb begin
    w_p_next = r_p_state;
    if (w_rx_ferr || w_timeout) begin
      w_p_next = P_IDLE;
    end else if (w_rx_done) begin
      case (r_p_state)
        P_IDLE:  w_p_next = (r_rx_shift == c_sync_byte) ? P_ADDR : P_IDLE;
        P_ADDR:  w_p_next = P_D3;
        P_D3:    w_p_next = P_D2;
        P_D2:    w_p_next = P_D1;
        P_D1:    w_p_next = P_D0;
        P_D0:    w_p_next = P_CSUM;
        default: w_p_next = P_IDLE;
      endcase
    end
  end

  always_ff @(posedge I_clk_40m or posedge I_rst) begin
    if (I_rst) begin
      r_addr       <= '0;
      r_data       <= '0;
      r_sum        <= '0;
      r_to_cnt     <= '0;
      r_commit_req <= 1'b0;
      r_cerr_req   <= 1'b0;
    end else begin
      if (w_rx_done) begin
        case (r_p_state)
          P_ADDR: begin
            r_addr <= r_rx_shift;
            r_sum  <= r_rx_shift;
          end
          P_D3, P_D2, P_D1, P_D0: begin
            r_data <= {r_data[23:0], r_rx_shift};
            r_sum  <= r_sum + r_rx_shift;
          end
          default: ;
        endcase
      end

      // Saturating inter-byte timer, only running inside a frame.
      if ((r_p_state == P_IDLE) || w_rx_done)
        r_to_cnt <= '0;
      else if (r_to_cnt != c_to_max)
        r_to_cnt <= r_to_cnt + 1'b1;

      r_commit_req <= w_csum_byte && w_csum_good;
      r_cerr_req   <= w_csum_byte && !w_csum_good;
    end
  end

  // --------------------------------------------------------------------------
  // Register file: the assembled word is held in r_data until the whole
  // frame is verified, so a register only ever changes in one cycle.
  // --------------------------------------------------------------------------
  logic         r_en;
  logic [1:0]   r_mode;
  logic [5:0]   r_pole_pair;
  logic [2:0]   r_dir;
  logic [95:0]  r_targets;
  logic [383:0] r_gains;
  logic         r_frame_ok, r_frame_err;

  always_ff @(posedge I_clk_40m or posedge I_rst) begin
    if (I_rst) begin
      r_en        <= 1'b0;
      r_mode      <= 2'd3;
      r_pole_pair <= 6'd7;
      r_dir       <= '0;
      r_targets   <= '0;
      r_gains     <= '0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_ok  <= r_commit_req;
      r_frame_err <= r_cerr_req | w_rx_ferr | w_timeout;
      if (r_commit_req) begin
        if (r_addr == 8'h00)
          r_en <= r_data[0];
        else if (r_addr == 8'h01)
          r_mode <= r_data[1:0];
        else if (r_addr == 8'h02)
          r_pole_pair <= r_data[5:0];
        else if (r_addr == 8'h03)
          r_dir <= r_data[2:0];
        else if (r_addr[7:4] == 4'h1)
          r_targets[{r_addr[2:0], 4'b0000} +: 16] <= r_data[15:0];
        else
          r_gains[{r_addr[3:0], 5'b00000} +: 32] <= r_data;
      end
    end
  end

  assign O_en             = r_en;
  assign O_control_mode   = r_mode;
  assign O_motor_polePair = r_pole_pair;
  assign O_dir_bits       = r_dir;
  assign O_targets        = r_targets;
  assign O_gains          = r_gains;
  assign O_frame_ok       = r_frame_ok;
  assign O_frame_err      = r_frame_err;

  // --------------------------------------------------------------------------
  // Optional acknowledge transmitter
  // --------------------------------------------------------------------------
`ifdef REGBANK_TX_ACK_EN
  logic            r_tx_busy;
  logic            r_tx_line;
  logic [8:0]      r_tx_shift;
  logic [3:0]      r_tx_bit;
  logic [BD_W-1:0] r_tx_cnt;

  // Requests arriving while busy are dropped so the current byte is intact.
  always_ff @(posedge I_clk_40m or posedge I_rst) begin
    if (I_rst) begin
      r_tx_busy  <= 1'b0;
      r_tx_line  <= 1'b1;
      r_tx_shift <= '1;
      r_tx_bit   <= '0;
      r_tx_cnt   <= '0;
    end else if (!r_tx_busy) begin
      r_tx_line <= 1'b1;
      if (r_frame_ok || r_frame_err) begin
        r_tx_busy  <= 1'b1;
        r_tx_line  <= 1'b0;
        r_tx_shift <= {1'b1, (r_frame_ok ? 8'h5A : 8'hEE)};
        r_tx_bit   <= '0;
        r_tx_cnt   <= '0;
      end
    end else if (r_tx_cnt == c_baud_last) begin
      r_tx_cnt <= '0;
      if (r_tx_bit == 4'd9) begin
        r_tx_busy <= 1'b0;
        r_tx_line <= 1'b1;
      end else begin
        r_tx_line  <= r_tx_shift[0];
        r_tx_shift <= {1'b1, r_tx_shift[8:1]};
        r_tx_bit   <= r_tx_bit + 1'b1;
      end
    end else begin
      r_tx_cnt <= r_tx_cnt + 1'b1;
    end
  end

  assign O_uart_tx = r_tx_line;
`else
  assign O_uart_tx = 1'b1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_foc_uart_regbank.sv
`default_nettype none
// ============================================================================
// Module   : tb_foc_uart_regbank
// Purpose  : Directed self-checking bench for foc_uart_regbank. Frames are
//            driven bit-serially on the UART line; expected register values
//            are hand-computed constants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_foc_uart_regbank;

  localparam int BD = 16;
  localparam int TO = 1000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rx  = 1'b1;
  logic         tx;
  logic         en;
  logic [1:0]   mode;
  logic [5:0]   pp;
  logic [2:0]   dir;
  logic [95:0]  targets;
  logic [383:0] gains;
  logic         frame_ok, frame_err;

  int checks = 0;
  int errors = 0;
  int ok_cyc = 0;
  int err_cyc = 0;
  int tx_low = 0;

  foc_uart_regbank #(.BAUD_DIV(BD), .TIMEOUT_CYC(TO)) u_dut (
    .I_clk_40m        (clk),
    .I_rst            (rst),
    .I_uart_rx        (rx),
    .O_uart_tx        (tx),
    .O_en             (en),
    .O_control_mode   (mode),
    .O_motor_polePair (pp),
    .O_dir_bits       (dir),
    .O_targets        (targets),
    .O_gains          (gains),
    .O_frame_ok       (frame_ok),
    .O_frame_err      (frame_err)
  );

  always #5 clk = ~clk;

  // Pulse-width accounting: a single-cycle pulse adds exactly one.
  always @(negedge clk) begin
    if (frame_ok)      ok_cyc++;
    if (frame_err)     err_cyc++;
    if (tx !== 1'b1)   tx_low++;
  end

  task automatic check_eq(input string tag, input logic [383:0] got, input logic [383:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (BD) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BD) @(posedge clk);
    end
    rx = stop_bit;
    repeat (BD) @(posedge clk);
    rx = 1'b1;
    repeat (BD) @(posedge clk);
  endtask

  // Seven bytes, first byte in the top octet.
  task automatic send_frame(input logic [55:0] f);
    for (int i = 6; i >= 0; i--) send_byte(f[i*8 +: 8], 1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_en"},   en,      1'b0);
    check_eq({tag, "_mode"}, mode,    2'd3);
    check_eq({tag, "_pp"},   pp,      6'd7);
    check_eq({tag, "_dir"},  dir,     3'd0);
    check_eq({tag, "_tgt"},  targets, 96'd0);
    check_eq({tag, "_gain"}, gains,   384'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [95:0]  exp_t;
    logic [383:0] exp_g;

    repeat (3) @(negedge clk);
    check_eq("rst_tx",  tx,        1'b1);
    check_eq("rst_ok",  frame_ok,  1'b0);
    check_eq("rst_err", frame_err, 1'b0);
    check_reset_values("rst");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Stray byte in IDLE is dropped, then enable write.
    send_byte(8'h33, 1'b1);
    send_frame(56'hA5_00_00_00_00_01_01);
    check_eq("en_set", en, 1'b1);
    check_eq("en_ok",  ok_cyc, 1);

    send_frame(56'hA5_21_00_00_03_E8_0C);
    check_eq("gain_iq_ki", gains[63:32], 32'd1000);
    check_eq("gain_ok",    ok_cyc, 2);

    send_frame(56'hA5_10_00_00_FF_38_47);
    check_eq("tgt_id", targets[15:0], 16'hFF38);

    send_frame(56'hA5_02_00_00_00_4B_4D);
    check_eq("pp_lsb", pp, 6'h0B);

    send_frame(56'hA5_03_12_34_56_FD_9C);
    check_eq("dir_lsb", dir, 3'd5);

    send_frame(56'hA5_2B_12_34_56_78_3F);
    send_frame(56'hA5_15_AB_CD_80_01_0E);
    exp_t = {16'h8001, 64'd0, 16'hFF38};
    exp_g = {32'h12345678, 288'd0, 32'd1000, 32'd0};
    check_eq("tgt_all",  targets, exp_t);
    check_eq("gain_all", gains,   exp_g);
    check_eq("ok_cnt7",  ok_cyc,  7);
    check_eq("err_cnt0", err_cyc, 0);

    // Bad checksum and unmapped address.
    send_frame(56'hA5_01_00_00_00_01_03);
    check_eq("csum_err",  err_cyc, 1);
    check_eq("csum_mode", mode, 2'd3);
    send_frame(56'hA5_04_00_00_00_01_05);
    check_eq("addr_err",  err_cyc, 2);
    check_eq("addr_tgt",  targets, exp_t);
    check_eq("addr_gain", gains, exp_g);
    check_eq("err_no_ok", ok_cyc, 7);

    // Inter-byte timeout, then a valid frame must be accepted.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h21, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (TO + 200) @(negedge clk);
    check_eq("to_err", err_cyc, 3);
    send_frame(56'hA5_01_00_00_00_01_02);
    check_eq("to_mode", mode, 2'd1);
    check_eq("to_ok",   ok_cyc, 8);
    check_eq("to_gain", gains, exp_g);

    // Stop bit low.
    send_byte(8'h55, 1'b0);
    repeat (4) @(negedge clk);
    check_eq("ferr", err_cyc, 4);

    // Short low glitch: neither byte nor error.
    rx = 1'b0;
    repeat (3) @(posedge clk);
    rx = 1'b1;
    repeat (4 * BD) @(negedge clk);
    check_eq("glitch", err_cyc, 4);

    // Reset after D2, remaining bytes must not commit.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h21, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("mid");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    send_byte(8'h03, 1'b1);
    send_byte(8'hE8, 1'b1);
    send_byte(8'h0C, 1'b1);
    repeat (4) @(negedge clk);
    check_eq("mid_gain", gains, 384'd0);
    check_eq("mid_ok",   ok_cyc, 8);
    check_eq("mid_err",  err_cyc, 4);

`ifndef REGBANK_TX_ACK_EN
    check_eq("tx_idle", tx_low, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
